bios_watchdog: RTL and testbench
================================

Name: bios_watchdog

Overview:
- BIOS boot watchdog. It sits directly downstream of the LPC register block and consumes its WriteBiosWD strobe and BiosRegister byte.
- It times BIOS POST. On expiry it requests a platform reset and flips the active BIOS flash select.
- It produces the 3-bit BiosStatus that the LPC read mux returns to software.
- Reset comes from the CPLD standby power-on reset, so BiosSel survives the host resets that this block itself requests.

Parameters:
- TICK_DIV, 33000000, LpcClock cycles per watchdog tick (1 s at 33 MHz); legal range 2..2^25.
- TIMEOUT_TICKS, 120, ticks from arm/kick to expiry; legal range 1..255.
- RST_PULSE, 3300, WdRstReq high time in LpcClock cycles (100 us); legal range >= 1.
- MAX_FAIL, 2, number of expiries after which the block halts.

Ports:
- LpcClock, in, 1: 33 MHz clock. This is the block's only clock.
- PciReset, in, 1: asynchronous, active-low reset.
- WriteBiosWD, in, 1: one-cycle strobe; the watchdog register is being written.
- BiosRegister, in, 8: watchdog register contents. Valid the cycle after WriteBiosWD. Bit7 = stop, bit6 = kick; bits 5:0 are ignored.
- BiosStatus, out, 3: {Running, Expired, BiosSel}.
- BiosSel, out, 1: active BIOS flash (0 = primary, 1 = backup).
- WdRstReq, out, 1: platform reset request, active-high pulse.
- WdHalted, out, 1: both BIOS images failed; level output.

Behaviour:
- Reset values: State = RUN, Prescaler = 0, TickCnt = 0, FailCnt = 0, WrDly = 0, BiosSel = 0, Expired = 0, WdRstReq = 0, WdHalted = 0. BiosStatus therefore resets to 3'b100.
- Write capture:
  - WrDly <= WriteBiosWD, because the register updates one cycle after the strobe.
  - The command is evaluated in the cycle WrDly = 1, using BiosRegister sampled in that same cycle.
  - Stop = WrDly & BiosRegister[7]. Kick = WrDly & BiosRegister[6] & ~BiosRegister[7]. Stop has priority over kick.
- Tick:
  - In RUN, Prescaler counts 0..TICK_DIV-1 and then wraps.
  - Tick = 1 when Prescaler == TICK_DIV-1.
  - On Tick, TickCnt increments.
- FSM RUN (Running = 1):
  - Kick: Prescaler = 0 and TickCnt = 0 next cycle; the state stays RUN.
  - Stop: go to STOP with Prescaler = 0 and TickCnt = 0.
  - Expiry: Tick with TickCnt == TIMEOUT_TICKS-1 goes to FIRE.
  - Exact timing: FIRE is entered exactly TIMEOUT_TICKS*TICK_DIV cycles after reset release or after the kick-evaluation cycle.
  - If expiry and Stop/Kick occur in the same cycle, Stop/Kick wins and FIRE is not entered.
- FSM STOP (Running = 0):
  - Counters are held at 0.
  - Kick re-arms the watchdog and returns to RUN with counters at 0.
  - Stop is a no-op.
- FSM FIRE:
  - The entry cycle registers the following:
    - BiosSel toggles.
    - Expired = 1 (sticky until reset).
    - FailCnt increments, saturating at MAX_FAIL.
    - WdRstReq = 1.
  - WdRstReq stays high for exactly RST_PULSE cycles. A pulse counter times this; it is 12 bits wide, widened as needed for RST_PULSE.
  - After the pulse, WdRstReq = 0. If FailCnt == MAX_FAIL, go to HALT; otherwise go to RUN with counters at 0.
  - All writes during FIRE are ignored.
- FSM HALT:
  - WdHalted = 1, Running = 0, WdRstReq = 0.
  - All writes are ignored; only PciReset exits HALT.
- Outputs and reset:
  - All outputs are registered and glitch-free.
  - BiosStatus is assembled from registered bits, with no combinational input path.
  - PciReset assertion at any time, including mid-pulse, immediately forces the reset values and drops WdRstReq asynchronously.

Test Plan:
(All scenarios use TICK_DIV = 4, TIMEOUT_TICKS = 3, RST_PULSE = 5, MAX_FAIL = 2.)
1. Release reset, no writes. Required response:
   - FIRE is entered 12 cycles after release.
   - WdRstReq is high for exactly 5 cycles.
   - BiosSel becomes 1 and BiosStatus becomes 3'b111, then 3'b111 again after the return to RUN.
2. Periodic kicks: WriteBiosWD with BiosRegister = 8'h40 every 10 cycles for 200 cycles. Required response:
   - WdRstReq never asserts; BiosStatus stays 3'b100.
   - Stop kicks: WdRstReq asserts 12 cycles after the last kick-evaluation cycle.
3. Write 8'h80 at cycle 5. Required response:
   - BiosStatus = 3'b000 from the next cycle, and there is no expiry for 100 cycles.
   - Then write 8'h40: Running = 1, and expiry follows 12 cycles later.
4. Write 8'hC0, with stop and kick together. Required response: STOP wins; BiosStatus = 3'b000.
   - Collision case: a kick evaluated in the exact expiry cycle (cycle 12) cancels FIRE, and WdRstReq stays 0.
5. Two consecutive expiries with no kicks. Required response:
   - Each expiry produces a 5-cycle WdRstReq pulse, and BiosSel goes 0 -> 1 -> 0.
   - After the second pulse, WdHalted = 1 and BiosStatus = 3'b010.
   - Later writes of 8'h40 have no effect.
6. Assert PciReset on cycle 2 of a WdRstReq pulse. Required response:
   - WdRstReq drops asynchronously; all outputs return to reset values, including BiosSel = 0.
   - After release, the first expiry again occurs at 12 cycles.

Source files
------------

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: times POST from arm/kick, requests a platform reset on expiry,
// flips the active BIOS flash and halts once every image has failed.
module bios_watchdog #(
    parameter int unsigned TICK_DIV      = 33000000,
    parameter int unsigned TIMEOUT_TICKS = 120,
    parameter int unsigned RST_PULSE     = 3300,
    parameter int unsigned MAX_FAIL      = 2
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       WriteBiosWD,
    input  logic [7:0] BiosRegister,
    output logic [2:0] BiosStatus,
    output logic       BiosSel,
    output logic       WdRstReq,
    output logic       WdHalted
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PC_W = ($clog2(RST_PULSE + 1) > 12) ? $clog2(RST_PULSE + 1) : 12;
    localparam int FC_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [7:0]      TC_LAST = 8'(TIMEOUT_TICKS - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(RST_PULSE - 1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_RUN,
        S_STOP,
        S_FIRE,
        S_HALT
    } state_t;

    state_t          r_state;
    logic [PS_W-1:0] r_presc;
    logic [7:0]      r_tick_cnt;
    logic [PC_W-1:0] r_pulse_cnt;
    logic [FC_W-1:0] r_fail_cnt;
    logic            r_wr_dly;
    logic            r_running;
    logic            r_expired;
    logic            r_bios_sel;
    logic            r_rst_req;
    logic            r_halted;

    logic w_stop;
    logic w_kick;
    logic w_tick;
    logic w_expire;
    logic w_unused;

    // The register byte is valid one cycle after the strobe, so commands are
    // decoded against the delayed strobe; stop outranks kick.
    assign w_stop   = r_wr_dly & BiosRegister[7];
    assign w_kick   = r_wr_dly & BiosRegister[6] & ~BiosRegister[7];
    assign w_tick   = (r_presc == PS_LAST);
    assign w_expire = w_tick & (r_tick_cnt == TC_LAST);
    assign w_unused = ^BiosRegister[5:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees pre-edge values regardless of statement order.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_state     <= S_RUN;
            r_presc     <= '0;
            r_tick_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_fail_cnt  <= '0;
            r_wr_dly    <= 1'b0;
            r_running   <= 1'b1;
            r_expired   <= 1'b0;
            r_bios_sel  <= 1'b0;
            r_rst_req   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_wr_dly <= WriteBiosWD;
            case (r_state)
                S_RUN: begin
                    if (w_stop) begin
                        r_state    <= S_STOP;
                        r_running  <= 1'b0;
                        r_presc    <= '0;
                        r_tick_cnt <= '0;
                    end else if (w_kick) begin
                        r_presc    <= '0;
                        r_tick_cnt <= '0;
                    end else if (w_expire) begin
                        r_state     <= S_FIRE;
                        r_presc     <= '0;
                        r_tick_cnt  <= '0;
                        r_pulse_cnt <= '0;
                        r_bios_sel  <= ~r_bios_sel;
                        r_expired   <= 1'b1;
                        r_rst_req   <= 1'b1;
                        if (r_fail_cnt != FC_MAX) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_presc    <= '0;
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_kick) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end

                // Writes are not decoded here: the reset pulse always runs to completion.
                S_FIRE: begin
                    if (r_pulse_cnt == PC_LAST) begin
                        r_rst_req <= 1'b0;
                        if (r_fail_cnt == FC_MAX) begin
                            r_state   <= S_HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    end
                end

                S_HALT: begin
                    r_running <= 1'b0;
                    r_rst_req <= 1'b0;
                    r_halted  <= 1'b1;
                end

                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign BiosStatus = {r_running, r_expired, r_bios_sel};
    assign BiosSel    = r_bios_sel;
    assign WdRstReq   = r_rst_req;
    assign WdHalted   = r_halted;

endmodule

// File: tb/tb_bios_watchdog.sv
// Self-checking bench for bios_watchdog: elapsed-time reference model compared every
// cycle, directed scenarios with literal timing expectations, then random stimulus.
module tb_bios_watchdog;

    localparam int T_DIV    = 4;
    localparam int T_TICKS  = 3;
    localparam int T_PULSE  = 5;
    localparam int T_FAIL   = 2;
    localparam int DEADLINE = T_TICKS * T_DIV;

    logic       clk;
    logic       rst_n;
    logic       WriteBiosWD;
    logic [7:0] BiosRegister;
    logic [2:0] BiosStatus;
    logic       BiosSel;
    logic       WdRstReq;
    logic       WdHalted;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;
    bit any_req;

    bios_watchdog #(
        .TICK_DIV     (T_DIV),
        .TIMEOUT_TICKS(T_TICKS),
        .RST_PULSE    (T_PULSE),
        .MAX_FAIL     (T_FAIL)
    ) dut (
        .LpcClock    (clk),
        .PciReset    (rst_n),
        .WriteBiosWD (WriteBiosWD),
        .BiosRegister(BiosRegister),
        .BiosStatus  (BiosStatus),
        .BiosSel     (BiosSel),
        .WdRstReq    (WdRstReq),
        .WdHalted    (WdHalted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one elapsed-cycle count since arming instead of prescaler/tick counters.
    typedef struct {
        bit wr_dly;
        bit armed;
        bit expired;
        bit sel;
        bit req;
        bit halted;
        int elapsed;
        int pulse_left;
        int fails;
    } model_t;

    localparam model_t MODEL_RST = '{wr_dly: 0, armed: 1, expired: 0, sel: 0, req: 0,
                                     halted: 0, elapsed: 0, pulse_left: 0, fails: 0};

    model_t m = MODEL_RST;

    function automatic model_t step(model_t c, bit wr, logic [7:0] rg);
        model_t n = c;
        bit stop = c.wr_dly && rg[7];
        bit kick = c.wr_dly && rg[6] && !rg[7];
        n.wr_dly = wr;
        if (c.halted) begin
            n.req = 0;
        end else if (c.pulse_left > 0) begin
            n.pulse_left = c.pulse_left - 1;
            if (n.pulse_left == 0) begin
                n.req     = 0;
                n.elapsed = 0;
                if (c.fails == T_FAIL) n.halted = 1;
            end
        end else if (!c.armed) begin
            if (kick) begin
                n.armed   = 1;
                n.elapsed = 0;
            end
        end else if (stop) begin
            n.armed   = 0;
            n.elapsed = 0;
        end else if (kick) begin
            n.elapsed = 0;
        end else begin
            n.elapsed = c.elapsed + 1;
            if (n.elapsed == DEADLINE) begin
                n.elapsed    = 0;
                n.sel        = !c.sel;
                n.expired    = 1;
                n.req        = 1;
                n.pulse_left = T_PULSE;
                n.fails      = (c.fails < T_FAIL) ? c.fails + 1 : T_FAIL;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= MODEL_RST;
        else        m <= step(m, WriteBiosWD, BiosRegister);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_status", 32'(BiosStatus),
                  32'({m.armed && !m.halted, m.expired, m.sel}));
            check("cmp_sel",    32'(BiosSel),  32'(m.sel));
            check("cmp_req",    32'(WdRstReq), 32'(m.req));
            check("cmp_halted", 32'(WdHalted), 32'(m.halted));
        end
    end

    // Called just after a negedge; release lands mid-low-phase so the next posedge is cycle 1.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        WriteBiosWD = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Returns just after the evaluation edge of the command.
    task automatic write_reg(input logic [7:0] val);
        WriteBiosWD = 1'b1;
        @(negedge clk);
        WriteBiosWD  = 1'b0;
        BiosRegister = val;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (WdRstReq) any_req = 1;
        end
    endtask

    task automatic measure_rise(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (WdRstReq === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    logic [2:0] tr_st   [1:45];
    logic       tr_req  [1:45];
    logic       tr_sel  [1:45];
    logic       tr_halt [1:45];

    initial begin
        int rise1, rise2, width, highs, cyc;
        rst_n        = 1'b0;
        WriteBiosWD  = 1'b0;
        BiosRegister = 8'h00;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        check("reset_status", 32'(BiosStatus), 32'h4);

        // Free-running expiries until halt
        do_reset();
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            tr_st[i]   = BiosStatus;
            tr_req[i]  = WdRstReq;
            tr_sel[i]  = BiosSel;
            tr_halt[i] = WdHalted;
        end
        rise1 = -1; rise2 = -1; width = 0; highs = 0;
        for (int i = 1; i <= 45; i++) begin
            if (tr_req[i]) highs++;
            if (tr_req[i] && rise1 < 0) rise1 = i;
        end
        if (rise1 > 0) begin
            for (int i = rise1; i <= 45 && tr_req[i]; i++) width++;
            for (int i = rise1 + width; i <= 45; i++)
                if (tr_req[i] && rise2 < 0) rise2 = i;
        end
        check("s1_first_fire", 32'(rise1), 32'd12);
        check("s1_pulse_width", 32'(width), 32'd5);
        check("s1_sel_after_fire", 32'(tr_sel[12]), 32'd1);
        check("s1_status_fire", 32'(tr_st[12]), 32'h7);
        check("s1_status_rerun", 32'(tr_st[20]), 32'h7);
        check("s5_second_fire", 32'(rise2), 32'd29);
        check("s5_sel_back", 32'(tr_sel[29]), 32'd0);
        check("s5_total_pulse", 32'(highs), 32'd10);
        check("s5_not_halted_mid", 32'(tr_halt[33]), 32'd0);
        check("s5_halted", 32'(tr_halt[34]), 32'd1);
        check("s5_status_halt", 32'(tr_st[40]), 32'h2);
        any_req = 0;
        for (int k = 0; k < 3; k++) begin
            write_reg(8'h40);
            idle(3);
        end
        idle(20);
        check("s5_halt_no_req", 32'(any_req), 32'd0);
        check("s5_halt_status", 32'(BiosStatus), 32'h2);
        check("s5_halt_level", 32'(WdHalted), 32'd1);

        // Periodic kicks
        do_reset();
        any_req = 0;
        for (int k = 0; k < 20; k++) begin
            write_reg(8'h40);
            idle(8);
        end
        check("s2_no_req", 32'(any_req), 32'd0);
        check("s2_status", 32'(BiosStatus), 32'h4);
        write_reg(8'h40);
        measure_rise(30, cyc);
        check("s2_fire_after_kick", 32'(cyc), 32'd12);

        // Stop, then re-arm
        do_reset();
        idle(4);
        write_reg(8'h80);
        check("s3_stopped_status", 32'(BiosStatus), 32'h0);
        any_req = 0;
        idle(100);
        check("s3_no_expiry", 32'(any_req), 32'd0);
        write_reg(8'h40);
        check("s3_rearm_status", 32'(BiosStatus), 32'h4);
        measure_rise(30, cyc);
        check("s3_fire_after_rearm", 32'(cyc), 32'd12);

        // Stop+kick together, then kick colliding with expiry
        do_reset();
        write_reg(8'hC0);
        check("s4_stop_wins", 32'(BiosStatus), 32'h0);
        do_reset();
        idle(10);
        write_reg(8'h40);
        check("s4_collision_no_req", 32'(WdRstReq), 32'd0);
        measure_rise(30, cyc);
        check("s4_collision_next_fire", 32'(cyc), 32'd12);

        // Asynchronous reset in the middle of a pulse
        do_reset();
        measure_rise(30, cyc);
        check("s6_first_fire", 32'(cyc), 32'd12);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_req_async_drop", 32'(WdRstReq), 32'd0);
        check("s6_sel_reset", 32'(BiosSel), 32'd0);
        check("s6_status_reset", 32'(BiosStatus), 32'h4);
        check("s6_halt_reset", 32'(WdHalted), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        measure_rise(30, cyc);
        check("s6_fire_after_release", 32'(cyc), 32'd12);

        // Randomized traffic, judged by the model every cycle
        do_reset();
        for (int seg = 0; seg < 20; seg++) begin
            int rate;
            case ($urandom_range(0, 2))
                0:       rate = 3;
                1:       rate = 10;
                default: rate = 30;
            endcase
            for (int c = 0; c < 200; c++) begin
                WriteBiosWD = ($urandom_range(0, rate - 1) == 0);
                case ($urandom_range(0, 4))
                    0:       BiosRegister = 8'h40;
                    1:       BiosRegister = 8'h80;
                    2:       BiosRegister = 8'hC0;
                    3:       BiosRegister = 8'h00;
                    default: BiosRegister = 8'($urandom);
                endcase
                @(negedge clk);
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end
        WriteBiosWD = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
